// File: rtl/div32_pkg.sv
// Shared definitions for the sequential divider: FSM state encodings and
// the quotient value reported on a divide by zero.
package div32_pkg;

  localparam int DIV_WIDTH = 32;

  // Divider control states, shared with the ALU/control decode.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Quotient reported when the divisor is zero (all ones).
  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div32_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep the
// difference only when it did not go negative.
module div32_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             qbit
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;

  // The shifted remainder needs WIDTH+1 bits so the compare stays exact for
  // divisors up to 2^WIDTH-1. Since t < 2*d, a negative result always sets
  // the top bit of the WIDTH+1 bit difference, which serves as the borrow.
  always_comb begin
    t      = {r, q_msb};
    diff   = t - {1'b0, d};
    qbit   = ~diff[WIDTH];
    r_next = qbit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  end

endmodule

// File: rtl/div32.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// behind a start/busy/done handshake.
module div32
  import div32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_reg, state_next;
  logic [WIDTH-1:0] r_reg, q_reg, d_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg, done_reg, dbz_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;

  logic [WIDTH-1:0] r_next;
  logic             qbit;
  logic [WIDTH-1:0] q_shifted;

  // Partial remainder stays below the divisor, so WIDTH bits hold it.
  div32_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .d      (d_reg),
    .r_next (r_next),
    .qbit   (qbit)
  );

  assign q_shifted = {q_reg[WIDTH-2:0], qbit};

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= DIV_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode; DONE accepts a new start so issue can be back to back.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DIV_IDLE, DIV_DONE: begin
        if (start) state_next = (b != '0) ? DIV_RUN : DIV_DONE;
        else       state_next = DIV_IDLE;
      end
      DIV_RUN: begin
        if (count_reg == '0) state_next = DIV_DONE;
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  // Working registers, iteration counter and held results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reg         <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      count_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      busy_reg <= (state_next == DIV_RUN);
      done_reg <= (state_next == DIV_DONE);
      case (state_reg)
        DIV_IDLE, DIV_DONE: begin
          if (start) begin
            if (b != '0) begin
              r_reg     <= '0;
              q_reg     <= a;
              d_reg     <= b;
              count_reg <= CW'(WIDTH - 1);
            end else begin
              // Divide by zero completes immediately without iterating.
              quotient_reg  <= '1;
              remainder_reg <= a;
              dbz_reg       <= 1'b1;
            end
          end
        end
        DIV_RUN: begin
          r_reg     <= r_next;
          q_reg     <= q_shifted;
          count_reg <= count_reg - CW'(1);
          if (count_reg == '0) begin
            quotient_reg  <= q_shifted;
            remainder_reg <= r_next;
            dbz_reg       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule
